// File: rtl/off_board_pkg.sv
// Types and constants shared by the off-board link encoder and decoder.
package off_board_pkg;

    typedef logic [31:0] off_board_word_t;

    typedef enum logic [0:0] {
        S_FIRST,
        S_SECOND
    } off_board_dec_state_e;

    // Number of identical beats the encoder sends per payload word.
    localparam int unsigned OFF_BOARD_REPEAT = 2;

endpackage

// File: rtl/off_board_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered read data port.
// rdata holds its last value while the FIFO is empty.
module off_board_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned FW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             do_push, do_pop;

    assign full    = (fill_q == FW'(DEPTH));
    assign empty   = (fill_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = rdata_q;
    assign fill    = fill_q;

    // Next fill/read pointer and the word that will sit at the head after this edge.
    always_comb begin
        fill_d   = fill_q;
        rd_ptr_d = rd_ptr_q;
        rdata_d  = rdata_q;
        if (do_push && !do_pop) begin
            fill_d = fill_q + 1'b1;
        end else if (!do_push && do_pop) begin
            fill_d = fill_q - 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (fill_d != '0) begin
            // The new head is the word being written when it lands on the head slot.
            if (do_push && (rd_ptr_d == wr_ptr_q)) begin
                rdata_d = wdata;
            end else begin
                rdata_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Storage array; no reset needed since fill gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointer, fill and head-data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            rdata_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: rtl/off_board_decode.sv
// Off-board link receiver: pairs duplicated beats, checks the copies agree,
// realigns by one beat on mismatch and buffers decoded words for the consumer.
module off_board_decode
    import off_board_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned LOCK_COUNT = 2,
    parameter int unsigned ERR_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          t0_data,
    input  logic                 t0_valid,
    output logic                 t0_ready,
    output logic [31:0]          i0_data,
    output logic                 i0_valid,
    input  logic                 i0_ready,
    output logic                 in_sync,
    output logic                 err_pulse,
    output logic [ERR_W-1:0]     err_count
);

    localparam int unsigned FW = $clog2(DEPTH) + 1;
    localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
    localparam logic [GW:0] LOCK_EXT = (GW + 1)'(LOCK_COUNT);

    off_board_dec_state_e state_q, state_d;
    off_board_word_t      hold_q, hold_d;
    logic [GW-1:0]        good_run_q, good_run_d;
    logic [GW:0]          run_inc;
    logic                 in_sync_q, in_sync_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]     err_count_q, err_count_d;
    logic                 accept, push;
    logic [FW-1:0]        fifo_fill;
    logic                 fifo_full, fifo_empty;
    logic                 unused_full;

    assign unused_full = fifo_full;

    // Ready depends only on registered state so the consumer cannot stall us combinationally.
    assign t0_ready = reset_n && ((state_q == S_FIRST) || (fifo_fill < FW'(DEPTH)));
    assign accept   = t0_valid && t0_ready;
    assign run_inc  = {1'b0, good_run_q} + 1'b1;

    // Pair-alignment FSM, sync tracking and error accounting.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        good_run_d  = good_run_q;
        in_sync_d   = in_sync_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        push        = 1'b0;
        if (accept) begin
            unique case (state_q)
                S_FIRST: begin
                    hold_d  = t0_data;
                    state_d = S_SECOND;
                end
                S_SECOND: begin
                    if (t0_data == hold_q) begin
                        // While regaining lock, only the pair that completes the run is kept.
                        push       = in_sync_q || (run_inc == LOCK_EXT);
                        good_run_d = (run_inc >= LOCK_EXT) ? LOCK_EXT[GW-1:0] : run_inc[GW-1:0];
                        if (run_inc >= LOCK_EXT) begin
                            in_sync_d = 1'b1;
                        end
                        state_d = S_FIRST;
                    end else begin
                        // Treat the new beat as the first copy of the next pair.
                        err_pulse_d = 1'b1;
                        err_count_d = (&err_count_q) ? err_count_q : err_count_q + 1'b1;
                        in_sync_d   = 1'b0;
                        good_run_d  = '0;
                        hold_d      = t0_data;
                    end
                end
            endcase
        end
    end

    // Decoder state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_FIRST;
            hold_q      <= '0;
            good_run_q  <= LOCK_EXT[GW-1:0];
            in_sync_q   <= 1'b1;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            good_run_q  <= good_run_d;
            in_sync_q   <= in_sync_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    off_board_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (hold_q),
        .pop     (i0_ready),
        .rdata   (i0_data),
        .fill    (fifo_fill),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign i0_valid  = !fifo_empty;
    assign in_sync   = in_sync_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_off_board_decode.sv
// Randomized bench for off_board_decode against a transaction-level reference model.
module tb_off_board_decode;

    localparam int DEPTH   = 4;
    localparam int LOCK    = 2;
    localparam int ERR_W   = 2;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
    localparam int BUDGET  = 200;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [31:0]       t0_data = '0;
    logic              t0_valid = 1'b0;
    logic              t0_ready;
    logic [31:0]       i0_data;
    logic              i0_valid;
    logic              i0_ready = 1'b0;
    logic              in_sync;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_count;

    always #5 clk = ~clk;

    off_board_decode #(
        .DEPTH      (DEPTH),
        .LOCK_COUNT (LOCK),
        .ERR_W      (ERR_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .t0_data   (t0_data),
        .t0_valid  (t0_valid),
        .t0_ready  (t0_ready),
        .i0_data   (i0_data),
        .i0_valid  (i0_valid),
        .i0_ready  (i0_ready),
        .in_sync   (in_sync),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a "first copy pending" flag plus a word queue for the buffer.
    bit          m_held;
    logic [31:0] m_hold;
    bit          m_sync;
    int          m_run;
    int          m_errs;
    bit          m_errp;
    logic [31:0] m_q[$];
    logic [31:0] m_last;
    bit          last_acc;
    int          pulses_seen = 0;
    logic [31:0] out_log[$];
    int          rdy_mode = 1;
    bit          gap_en = 0;

    task automatic model_reset();
        m_held = 0; m_hold = '0; m_sync = 1; m_run = LOCK; m_errs = 0; m_errp = 0;
        m_q.delete(); m_last = '0;
    endtask

    // Applies the current inputs to the model as the DUT will see them at the next edge.
    task automatic model_edge();
        bit rdy;
        bit acc;
        if (!reset_n) begin
            model_reset();
            last_acc = 0;
            return;
        end
        rdy = !m_held || (m_q.size() < DEPTH);
        acc = t0_valid && rdy;
        m_errp = 0;
        if (i0_ready && m_q.size() > 0) m_last = m_q.pop_front();
        if (acc) begin
            if (!m_held) begin
                m_hold = t0_data;
                m_held = 1;
            end else if (t0_data == m_hold) begin
                if (m_sync || (m_run + 1 == LOCK)) m_q.push_back(m_hold);
                if (m_run + 1 >= LOCK) m_sync = 1;
                m_run = (m_run + 1 > LOCK) ? LOCK : m_run + 1;
                m_held = 0;
            end else begin
                m_errp = 1;
                if (m_errs < ERR_MAX) m_errs++;
                m_sync = 0;
                m_run = 0;
                m_hold = t0_data;
            end
        end
        last_acc = acc;
    endtask

    task automatic check_outputs();
        bit exp_rdy;
        exp_rdy = reset_n && (!m_held || (m_q.size() < DEPTH));
        check_eq("t0_ready", 32'(t0_ready), 32'(exp_rdy));
        check_eq("i0_valid", 32'(i0_valid), 32'(m_q.size() > 0));
        check_eq("i0_data", i0_data, (m_q.size() > 0) ? m_q[0] : m_last);
        check_eq("in_sync", 32'(in_sync), 32'(m_sync));
        check_eq("err_pulse", 32'(err_pulse), 32'(m_errp));
        check_eq("err_count", 32'(err_count), 32'(m_errs));
        if (err_pulse === 1'b1) pulses_seen++;
    endtask

    // One clock: drive ready, advance model, cross the edge, check on the falling edge.
    task automatic step();
        case (rdy_mode)
            0:       i0_ready = 1'b0;
            1:       i0_ready = 1'b1;
            default: i0_ready = ($urandom % 4) != 0;
        endcase
        if (reset_n && i0_valid && i0_ready) out_log.push_back(i0_data);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send_beat(input logic [31:0] d);
        int n;
        n = 0;
        if (gap_en) begin
            t0_valid = 1'b0;
            repeat ($urandom % 3) step();
        end
        t0_valid = 1'b1;
        t0_data  = d;
        do begin
            step();
            n++;
        end while (!last_acc && n < BUDGET);
        if (!last_acc) check_eq("accept_timeout", 32'(last_acc), 32'd1);
        t0_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [31:0] d);
        send_beat(d);
        send_beat(d);
    endtask

    task automatic idle(input int n);
        t0_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        int p0;
        logic [31:0] w;
        model_reset();

        // Reset state.
        reset_n = 1'b0;
        step();
        step();
        check_eq("reset_sync", 32'(in_sync), 32'd1);
        check_eq("reset_errs", 32'(err_count), 32'd0);
        reset_n = 1'b1;
        step();

        // Clean pairs.
        rdy_mode = 1;
        out_log.delete();
        send_pair(32'hA); send_pair(32'hB); send_pair(32'hC);
        idle(4);
        check_eq("clean_count", 32'(out_log.size()), 32'd3);
        if (out_log.size() == 3) begin
            check_eq("clean_w0", out_log[0], 32'hA);
            check_eq("clean_w2", out_log[2], 32'hC);
        end
        check_eq("clean_errs", 32'(err_count), 32'd0);

        // Misalignment: 0x2 dropped while regaining lock.
        out_log.delete();
        p0 = pulses_seen;
        send_beat(32'h1);
        send_pair(32'h2); send_pair(32'h3); send_pair(32'h4);
        idle(4);
        check_eq("mis_pulses", 32'(pulses_seen - p0), 32'd1);
        check_eq("mis_errs", 32'(err_count), 32'd1);
        check_eq("mis_sync", 32'(in_sync), 32'd1);
        check_eq("mis_count", 32'(out_log.size()), 32'd2);
        if (out_log.size() == 2) check_eq("mis_w0", out_log[0], 32'h3);

        // Backpressure with the fifth pair stuck on its second copy.
        rdy_mode = 0;
        out_log.delete();
        for (int i = 0; i < 4; i++) send_pair(32'h100 + 32'(i));
        send_beat(32'h104);
        t0_data  = 32'h104;
        t0_valid = 1'b1;
        repeat (3) step();
        check_eq("bp_ready", 32'(t0_ready), 32'd0);
        check_eq("bp_valid", 32'(i0_valid), 32'd1);
        rdy_mode = 1;
        send_beat(32'h104);
        idle(8);
        check_eq("bp_count", 32'(out_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < out_log.size(); i++)
            check_eq("bp_order", out_log[i], 32'h100 + 32'(i));

        // Full FIFO with continuous pairs and a consumer always ready.
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) send_pair(32'h200 + 32'(i));
        rdy_mode = 1;
        for (int i = 4; i < 10; i++) send_pair(32'h200 + 32'(i));
        idle(8);

        // Saturating error count: five consecutive mismatches.
        p0 = pulses_seen;
        for (int i = 0; i < 6; i++) send_beat(32'h10 + 32'(i));
        idle(2);
        check_eq("sat_pulses", 32'(pulses_seen - p0), 32'd5);
        check_eq("sat_errs", 32'(err_count), 32'(ERR_MAX));
        send_beat(32'h15);
        idle(2);

        // Reset with buffered words and a held first copy.
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) send_pair(32'h20 + 32'(i));
        send_beat(32'h23);
        reset_n = 1'b0;
        step();
        check_eq("rst_valid", 32'(i0_valid), 32'd0);
        check_eq("rst_ready", 32'(t0_ready), 32'd0);
        reset_n = 1'b1;
        rdy_mode = 1;
        out_log.delete();
        send_pair(32'h55);
        idle(4);
        check_eq("rst_count", 32'(out_log.size()), 32'd1);
        if (out_log.size() == 1) check_eq("rst_word", out_log[0], 32'h55);

        // Randomized traffic: mostly pairs, occasional lone beats, random gaps and stalls.
        rdy_mode = 2;
        gap_en = 1;
        for (int i = 0; i < 300; i++) begin
            w = ($urandom % 2) ? 32'($urandom % 8) : $urandom;
            if ($urandom % 8 == 0) send_beat(w);
            else send_pair(w);
        end
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/off_board_decode.md
Name: off_board_decode

Overview:
- Receive-side counterpart of the off-board link encoder.
- The encoder sends every 32-bit payload word as two consecutive identical beats. This block pairs the beats, checks that the two copies match and emits one payload word per valid pair.
- It tracks pair alignment, realigns by one beat on a mismatch and reports errors.
- Sits between the off-board receive stream and the on-board consumer, with a small output FIFO decoupling the two.

Parameters:
- DEPTH, 4, output FIFO depth in 32-bit words (power of two, >=2).
- LOCK_COUNT, 2, consecutive matched pairs required to regain sync after a mismatch (>=1).
- ERR_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  synchronous reset, active low.
- t0_data  in  32  received beat.
- t0_valid  in  1  beat valid.
- t0_ready  out  1  beat accepted when t0_valid && t0_ready.
- i0_data  out  32  decoded payload word.
- i0_valid  out  1  payload valid.
- i0_ready  in  1  consumer ready.
- in_sync  out  1  1 = pair alignment trusted.
- err_pulse  out  1  one-cycle pulse per detected mismatch.
- err_count  out  ERR_W  saturating mismatch count.

Behaviour:
- Reset (reset_n==0 at a clk edge):
  - State goes to S_FIRST; hold register is cleared.
  - FIFO is flushed: fill=0, i0_valid=0, i0_data=0.
  - t0_ready=0 during reset. in_sync=1, good_run=LOCK_COUNT, err_pulse=0, err_count=0.
  - Reset asserted mid-pair discards the held beat. Reset asserted mid-FIFO drops all buffered words.
- Two states: S_FIRST (waiting for the first copy) and S_SECOND (holding the first copy, comparing the next beat).
- t0_ready:
  - S_FIRST: 1.
  - S_SECOND: (fill < DEPTH), using registered fill only.
  - No combinational path from i0_ready to t0_ready.
- S_FIRST with an accepted beat: hold <= t0_data, go to S_SECOND.
- S_SECOND with an accepted beat and t0_data == hold (match):
  - If in_sync, or good_run+1 == LOCK_COUNT: push hold into the FIFO.
  - Otherwise drop the word.
  - good_run <= min(good_run+1, LOCK_COUNT).
  - in_sync <= 1 when good_run+1 >= LOCK_COUNT.
  - Go to S_FIRST.
- S_SECOND with an accepted beat and t0_data != hold (mismatch):
  - err_pulse=1 for the next cycle only. err_count += 1, saturating at all-ones.
  - in_sync <= 0, good_run <= 0.
  - hold <= t0_data, so the new beat becomes the first copy (one-beat realign). Stay in S_SECOND.
- No accepted beat: state and hold are unchanged; back-to-back gaps between copies are legal.
- FIFO:
  - First-word-fall-through behaviour.
  - Latency: second copy accepted at edge N -> i0_valid=1 with that word after edge N (visible in cycle N+1).
  - i0_data stays stable while i0_valid && !i0_ready.
- FIFO push and pop in the same cycle: both take effect, fill is unchanged.
  - When full, a push cannot occur because t0_ready=0 in S_SECOND. The pop frees space, and t0_ready rises the following cycle.
- Empty FIFO: i0_valid=0, i0_data holds its last value.
- Fill and pointer widths are clog2(DEPTH)+1 and clog2(DEPTH), with natural pointer wrap-around.

Decomposition:
- Shared package off_board_pkg holds:
  - typedef off_board_word_t (logic [31:0]).
  - enum off_board_dec_state_e {S_FIRST, S_SECOND}.
  - The constant OFF_BOARD_REPEAT=2, shared with the encoder.
- One sub-module, off_board_fifo: a synchronous FWFT FIFO with parameters DEPTH and WIDTH and ports push/pop/fill/full/empty. It is reusable by the encoder when its buffer is restored.

Test Plan:
- Clean pairs: beats 0xA,0xA,0xB,0xB,0xC,0xC with i0_ready=1 -> i0 emits 0xA,0xB,0xC, each one cycle after its second copy; err_count=0; in_sync stays 1.
- Misalignment: beats 0x1,0x2,0x2,0x3,0x3,0x4,0x4 -> err_pulse once after the 0x2 beat; err_count=1; 0x2 is dropped (good_run=1 < 2); 0x3 and 0x4 are emitted; in_sync returns to 1 at the 0x3 pair.
- Backpressure: i0_ready=0, send 5 pairs with DEPTH=4 -> 4 words buffered, t0_ready=0 while holding the 5th first copy. Raise i0_ready -> all 5 words out in order, none lost or duplicated.
- Simultaneous push/pop at full: fill=4 with i0_ready=1 every cycle and continuous pairs -> throughput of 1 word per 2 cycles, fill never exceeds 4.
- Error saturation: ERR_W=2, 5 mismatches -> err_count=3 and held there, err_pulse fires 5 times.
- Reset mid-operation: assert reset_n=0 with the FIFO holding 3 words and in S_SECOND -> next cycle i0_valid=0, t0_ready=0. After release, pair 0x55,0x55 -> a single 0x55 output, no stale data.
